// File: rtl/pzcorebus_request_command_data_aligner.sv
// Re-aligns the command and write-data streams coming out of the request
// async FIFO. A write command is only issued together with its first data
// beat. The block counts the remaining beats of the burst, generates
// o_mdata_last, and blocks any further command until the burst has drained.
// All command/data fields pass through combinationally (zero latency).
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_mcmd_valid / o_scmd_accept      upstream command handshake
//   i_mcmd, i_mid, i_maddr, i_mlength upstream command fields
//   i_mdata_valid / o_sdata_accept    upstream write-data handshake
//   i_mdata, i_mdata_byteen           upstream write-data fields
//   o_mcmd_valid / i_scmd_accept      downstream command handshake
//   o_mcmd, o_mid, o_maddr, o_mlength downstream command fields
//   o_mdata_valid / i_sdata_accept    downstream write-data handshake
//   o_mdata, o_mdata_byteen           downstream write-data fields
//   o_mdata_last                      final beat of the current burst
//   o_busy                            a write burst is still draining
module pzcorebus_request_command_data_aligner #(
  parameter int ID_WIDTH          = 4,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int LENGTH_WIDTH      = 8,
  parameter int DATA_WIDTH        = 64,
  parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_mcmd_valid,
  output logic                         o_scmd_accept,
  input  logic [1:0]                   i_mcmd,
  input  logic [ID_WIDTH-1:0]          i_mid,
  input  logic [ADDRESS_WIDTH-1:0]     i_maddr,
  input  logic [LENGTH_WIDTH-1:0]      i_mlength,
  input  logic                         i_mdata_valid,
  output logic                         o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]        i_mdata,
  input  logic [BYTE_ENABLE_WIDTH-1:0] i_mdata_byteen,
  output logic                         o_mcmd_valid,
  input  logic                         i_scmd_accept,
  output logic [1:0]                   o_mcmd,
  output logic [ID_WIDTH-1:0]          o_mid,
  output logic [ADDRESS_WIDTH-1:0]     o_maddr,
  output logic [LENGTH_WIDTH-1:0]      o_mlength,
  output logic                         o_mdata_valid,
  input  logic                         i_sdata_accept,
  output logic [DATA_WIDTH-1:0]        o_mdata,
  output logic [BYTE_ENABLE_WIDTH-1:0] o_mdata_byteen,
  output logic                         o_mdata_last,
  output logic                         o_busy
);

  // One extra bit so that mlength==0 (2**LENGTH_WIDTH beats) is representable.
  localparam int unsigned COUNT_WIDTH = LENGTH_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

  state_e                 state;
  state_e                 state_next;
  logic [COUNT_WIDTH-1:0] beat_count;
  logic [COUNT_WIDTH-1:0] beat_count_next;
  logic [COUNT_WIDTH-1:0] burst_len;
  logic                   is_write;
  logic                   cmd_hs;
  logic                   first_hs;

  // Field pass-through.
  assign o_mcmd         = i_mcmd;
  assign o_mid          = i_mid;
  assign o_maddr        = i_maddr;
  assign o_mlength      = i_mlength;
  assign o_mdata        = i_mdata;
  assign o_mdata_byteen = i_mdata_byteen;

  // Reserved command code 3 is treated as a read.
  assign is_write  = (i_mcmd == 2'd1) || (i_mcmd == 2'd2);
  assign burst_len = (i_mlength == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}}
                                       : COUNT_WIDTH'(i_mlength);

  // State and remaining-beat counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      beat_count <= '0;
    end else begin
      state      <= state_next;
      beat_count <= beat_count_next;
    end
  end

  // Next state and handshake steering; everything is closed while in reset.
  always_comb begin
    state_next      = state;
    beat_count_next = beat_count;
    o_mcmd_valid    = 1'b0;
    o_scmd_accept   = 1'b0;
    o_mdata_valid   = 1'b0;
    o_sdata_accept  = 1'b0;
    o_mdata_last    = 1'b0;
    o_busy          = 1'b0;
    cmd_hs          = 1'b0;
    first_hs        = 1'b0;

    if (!i_rst) begin
      o_busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (is_write) begin
            // Command and first beat are presented together; the upstream
            // command is only popped if its first beat is there as well, and
            // the first beat only moves with (or after) the command.
            o_mcmd_valid   = i_mcmd_valid & i_mdata_valid;
            o_mdata_valid  = i_mcmd_valid & i_mdata_valid;
            o_scmd_accept  = i_scmd_accept & i_mdata_valid;
            o_sdata_accept = i_mcmd_valid & i_mdata_valid
                           & i_scmd_accept & i_sdata_accept;
            o_mdata_last   = o_mdata_valid & (burst_len == COUNT_WIDTH'(1));
            cmd_hs         = o_mcmd_valid & i_scmd_accept;
            first_hs       = cmd_hs & i_sdata_accept;
            if (cmd_hs && !(first_hs && (burst_len == COUNT_WIDTH'(1)))) begin
              state_next      = DATA;
              beat_count_next = burst_len - COUNT_WIDTH'(first_hs);
            end
          end else begin
            o_mcmd_valid  = i_mcmd_valid;
            o_scmd_accept = i_scmd_accept;
          end
        end
        DATA: begin
          o_mdata_valid  = i_mdata_valid;
          o_sdata_accept = i_sdata_accept;
          o_mdata_last   = (beat_count == COUNT_WIDTH'(1));
          if (i_mdata_valid && i_sdata_accept) begin
            beat_count_next = beat_count - COUNT_WIDTH'(1);
            if (beat_count == COUNT_WIDTH'(1)) begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
